// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single-beat AXI3 master.
// One read and one write may be outstanding; data responses stay in order.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_wstrb,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   input  logic [3:0]  bid,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready
);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_e;
   typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} w_state_e;

   r_state_e    r_state_q, r_state_d;
   logic        r_owner_q, r_owner_d;
   logic [31:0] r_addr_q, r_addr_d;
   logic [1:0]  r_size_q, r_size_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        inst_ok_q, inst_ok_d;
   logic        data_ok_q, data_ok_d;

   w_state_e    w_state_q, w_state_d;
   logic [31:0] w_addr_q, w_addr_d;
   logic [1:0]  w_size_q, w_size_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;

   logic        data_rd_acc;
   logic        data_wr_acc;
   logic        inst_acc;
   logic        data_rd_busy;
   logic        r_hs;
   logic        unused_ok;

   // Owner bit: 1 = data port, 0 = instruction port.
   always_comb begin
      data_rd_busy = (r_state_q != R_IDLE) && r_owner_q;
      data_rd_acc  = (r_state_q == R_IDLE) && data_req && !data_wr
                     && (w_state_q == W_IDLE);
      data_wr_acc  = (w_state_q == W_IDLE) && data_req && data_wr
                     && !data_rd_busy;
      inst_acc     = (r_state_q == R_IDLE) && inst_req
                     && !data_rd_acc && !data_wr_acc;
      r_hs         = (r_state_q == R_R) && rvalid;
   end

   always_comb begin
      r_state_d    = r_state_q;
      r_owner_d    = r_owner_q;
      r_addr_d     = r_addr_q;
      r_size_d     = r_size_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_ok_d    = 1'b0;
      data_ok_d    = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            if (data_rd_acc) begin
               r_state_d = R_AR;
               r_owner_d = 1'b1;
               r_addr_d  = data_addr;
               r_size_d  = data_size;
            end else if (inst_acc) begin
               r_state_d = R_AR;
               r_owner_d = 1'b0;
               r_addr_d  = inst_addr;
               r_size_d  = inst_size;
            end
         end
         R_AR: begin
            if (arready) r_state_d = R_R;
         end
         R_R: begin
            if (r_hs) begin
               r_state_d = R_IDLE;
               if (r_owner_q) begin
                  data_rdata_d = rdata;
                  data_ok_d    = 1'b1;
               end else begin
                  inst_rdata_d = rdata;
                  inst_ok_d    = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // A write response can never coincide with a data read response.
      if (w_state_q == W_B && bvalid) data_ok_d = 1'b1;
   end

   always_comb begin
      w_state_d = w_state_q;
      w_addr_d  = w_addr_q;
      w_size_d  = w_size_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      unique case (w_state_q)
         W_IDLE: begin
            if (data_wr_acc) begin
               w_state_d = W_SEND;
               w_addr_d  = data_addr;
               w_size_d  = data_size;
               w_data_d  = data_wdata;
               w_strb_d  = data_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         W_SEND: begin
            if (!aw_done_q && awready) aw_done_d = 1'b1;
            if (!w_done_q && wready) w_done_d = 1'b1;
            if (aw_done_d && w_done_d) begin
               w_state_d = W_B;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         W_B: begin
            if (bvalid) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state_q    <= R_IDLE;
         r_owner_q    <= 1'b0;
         r_addr_q     <= 32'd0;
         r_size_q     <= 2'd0;
         inst_rdata_q <= 32'd0;
         data_rdata_q <= 32'd0;
         inst_ok_q    <= 1'b0;
         data_ok_q    <= 1'b0;
         w_state_q    <= W_IDLE;
         w_addr_q     <= 32'd0;
         w_size_q     <= 2'd0;
         w_data_q     <= 32'd0;
         w_strb_q     <= 4'd0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
      end else begin
         r_state_q    <= r_state_d;
         r_owner_q    <= r_owner_d;
         r_addr_q     <= r_addr_d;
         r_size_q     <= r_size_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_ok_q    <= inst_ok_d;
         data_ok_q    <= data_ok_d;
         w_state_q    <= w_state_d;
         w_addr_q     <= w_addr_d;
         w_size_q     <= w_size_d;
         w_data_q     <= w_data_d;
         w_strb_q     <= w_strb_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
      end
   end

   assign inst_addr_ok = inst_acc;
   assign data_addr_ok = data_rd_acc || data_wr_acc;
   assign inst_data_ok = inst_ok_q;
   assign data_data_ok = data_ok_q;
   assign inst_rdata   = inst_rdata_q;
   assign data_rdata   = data_rdata_q;

   assign arid    = r_owner_q ? DATA_ID : INST_ID;
   assign araddr  = r_addr_q;
   assign arlen   = 4'd0;
   assign arsize  = {1'b0, r_size_q};
   assign arburst = 2'b01;
   assign arlock  = 2'd0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign arvalid = (r_state_q == R_AR);
   assign rready  = (r_state_q == R_R);

   assign awid    = DATA_ID;
   assign awaddr  = w_addr_q;
   assign awlen   = 4'd0;
   assign awsize  = {1'b0, w_size_q};
   assign awburst = 2'b01;
   assign awlock  = 2'd0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign awvalid = (w_state_q == W_SEND) && !aw_done_q;
   assign wid     = DATA_ID;
   assign wdata   = w_data_q;
   assign wstrb   = w_strb_q;
   assign wlast   = 1'b1;
   assign wvalid  = (w_state_q == W_SEND) && !w_done_q;
   assign bready  = (w_state_q == W_B);

   // Single-beat, in-order slave: ids, responses and rlast carry no information.
   assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge; the bench plays the AXI slave by hand.
module tb_sram_axi_bridge;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [1:0]  awlock;
   logic [3:0]  awcache;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [3:0]  wid;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   int n_cmp = 0;
   int n_err = 0;

   sram_axi_bridge dut (
      .aclk(aclk), .aresetn(aresetn),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_wstrb(data_wstrb), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache),
      .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache),
      .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the falling edge; checks follow 1 ns later.
   task automatic step();
      @(negedge aclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      aresetn = 1'b0;
      inst_req = 0; inst_size = 2'd2; inst_addr = '0;
      data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0;
      data_wdata = '0; data_wstrb = '0;
      arready = 0; rid = 4'hF; rdata = '0; rresp = 2'b10; rlast = 0;
      rvalid = 0; awready = 0; wready = 0; bid = 4'hF; bresp = 2'b10;
      bvalid = 0;
      step(); step(); #1;
      check("rst_arvalid", 32'(arvalid), 0);
      check("rst_awvalid", 32'(awvalid), 0);
      check("rst_wvalid", 32'(wvalid), 0);
      check("rst_rready", 32'(rready), 0);
      check("rst_bready", 32'(bready), 0);
      check("rst_ok", 32'({inst_addr_ok, inst_data_ok,
                          data_addr_ok, data_data_ok}), 0);
      check("rst_inst_rdata", inst_rdata, 0);
      check("rst_data_rdata", data_rdata, 0);
      check("const_ar", 32'({arlen, arburst, arlock, arcache, arprot}),
            32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0}));
      check("const_aw", 32'({awlen, awburst, awlock, awcache, awprot, wlast}),
            32'({4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1}));

      // 1: instruction fetch, arready on the third AR cycle
      step(); aresetn = 1'b1;
      step();
      inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2; #1;
      check("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
      check("t1_data_addr_ok", 32'(data_addr_ok), 0);
      step(); inst_req = 0; #1;
      check("t1_arid", 32'(arid), 0);
      check("t1_arsize", 32'(arsize), 2);
      check("t1_araddr", araddr, 32'hBFC0_0000);
      for (int i = 0; i < 3; i++) begin
         check("t1_arvalid_hold", 32'(arvalid), 1);
         check("t1_araddr_hold", araddr, 32'hBFC0_0000);
         if (i == 2) arready = 1;
         if (i < 2) step();
      end
      step(); arready = 0; #1;
      check("t1_arvalid_drop", 32'(arvalid), 0);
      check("t1_rready", 32'(rready), 1);
      rvalid = 1; rdata = 32'h3C1D_0000; #1;
      check("t1_no_early_ok", 32'(inst_data_ok), 0);
      step(); rvalid = 0; #1;
      check("t1_inst_data_ok", 32'(inst_data_ok), 1);
      check("t1_inst_rdata", inst_rdata, 32'h3C1D_0000);
      check("t1_rready_off", 32'(rready), 0);
      step();
      check("t1_ok_single", 32'(inst_data_ok), 0);

      // 2: simultaneous inst and data read; data wins
      inst_req = 1; inst_addr = 32'hBFC0_0004;
      data_req = 1; data_wr = 0; data_addr = 32'h8000_0010;
      data_size = 2'd1; #1;
      check("t2_data_addr_ok", 32'(data_addr_ok), 1);
      check("t2_inst_addr_ok", 32'(inst_addr_ok), 0);
      step(); data_req = 0; #1;
      check("t2_arid", 32'(arid), 1);
      check("t2_araddr", araddr, 32'h8000_0010);
      check("t2_arsize", 32'(arsize), 1);
      check("t2_inst_wait", 32'(inst_addr_ok), 0);
      arready = 1;
      step(); arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF; #1;
      check("t2_inst_wait_r", 32'(inst_addr_ok), 0);
      step(); rvalid = 0; #1;
      check("t2_data_data_ok", 32'(data_data_ok), 1);
      check("t2_data_rdata", data_rdata, 32'hDEAD_BEEF);
      check("t2_inst_accept", 32'(inst_addr_ok), 1);
      check("t2_inst_no_ok", 32'(inst_data_ok), 0);
      step(); inst_req = 0; #1;
      check("t2_arid_inst", 32'(arid), 0);
      check("t2_araddr_inst", araddr, 32'hBFC0_0004);
      arready = 1;
      step(); arready = 0; rvalid = 1; rdata = 32'h1111_2222;
      step(); rvalid = 0; #1;
      check("t2_inst_data_ok", 32'(inst_data_ok), 1);
      check("t2_inst_rdata", inst_rdata, 32'h1111_2222);
      check("t2_data_quiet", 32'(data_data_ok), 0);

      // 3: write with AW/W skew
      step();
      data_req = 1; data_wr = 1; data_addr = 32'h8000_1000;
      data_wdata = 32'h1234_5678; data_wstrb = 4'b0011; data_size = 2'd2; #1;
      check("t3_addr_ok", 32'(data_addr_ok), 1);
      check("t3_inst_addr_ok", 32'(inst_addr_ok), 0);
      step(); data_req = 0; #1;
      check("t3_awvalid", 32'(awvalid), 1);
      check("t3_wvalid", 32'(wvalid), 1);
      check("t3_bready_send", 32'(bready), 0);
      check("t3_awaddr", awaddr, 32'h8000_1000);
      check("t3_wdata", wdata, 32'h1234_5678);
      check("t3_wstrb", 32'(wstrb), 32'h3);
      check("t3_ids", 32'({awid, wid}), 32'h11);
      check("t3_awsize", 32'(awsize), 2);
      step(); awready = 1; #1;
      check("t3_awvalid_hs", 32'(awvalid), 1);
      step(); awready = 0; #1;
      check("t3_awvalid_drop", 32'(awvalid), 0);
      check("t3_wvalid_hold", 32'(wvalid), 1);
      check("t3_bready_wait", 32'(bready), 0);
      step();
      check("t3_wvalid_hold2", 32'(wvalid), 1);
      step(); wready = 1; #1;
      check("t3_wdata_hold", wdata, 32'h1234_5678);
      step(); wready = 0; #1;
      check("t3_wvalid_drop", 32'(wvalid), 0);
      check("t3_bready", 32'(bready), 1);
      check("t3_no_early_ok", 32'(data_data_ok), 0);
      bvalid = 1;
      step(); bvalid = 0; #1;
      check("t3_data_data_ok", 32'(data_data_ok), 1);
      check("t3_bready_off", 32'(bready), 0);
      step();
      check("t3_ok_single", 32'(data_data_ok), 0);

      // 4: read-after-write hazard with an overlapping fetch
      data_req = 1; data_wr = 1; data_addr = 32'h8000_2000;
      data_wdata = 32'hA5A5_A5A5; data_wstrb = 4'hF; #1;
      check("t4_wr_accept", 32'(data_addr_ok), 1);
      step();
      data_wr = 0; inst_req = 1; inst_addr = 32'hBFC0_0100;
      awready = 1; wready = 1; #1;
      check("t4_rd_blocked", 32'(data_addr_ok), 0);
      check("t4_inst_proceeds", 32'(inst_addr_ok), 1);
      step(); inst_req = 0; awready = 0; wready = 0; #1;
      check("t4_rd_blocked_b", 32'(data_addr_ok), 0);
      check("t4_bready", 32'(bready), 1);
      check("t4_ar_inst", 32'({arvalid, arid}), 32'h10);
      arready = 1; bvalid = 1;
      step(); arready = 0; bvalid = 0; #1;
      check("t4_wr_done", 32'(data_data_ok), 1);
      check("t4_rd_blocked_r", 32'(data_addr_ok), 0);
      rvalid = 1; rdata = 32'h0BAD_0BAD;
      step(); rvalid = 0; #1;
      check("t4_inst_data_ok", 32'(inst_data_ok), 1);
      check("t4_inst_rdata", inst_rdata, 32'h0BAD_0BAD);
      check("t4_rd_accept", 32'(data_addr_ok), 1);
      step(); data_req = 0; #1;
      check("t4_ar_data", 32'({arvalid, arid}), 32'h11);
      check("t4_araddr", araddr, 32'h8000_2000);
      arready = 1;
      step(); arready = 0; rvalid = 1; rdata = 32'hA5A5_A5A5;
      step(); rvalid = 0; #1;
      check("t4_rd_ok", 32'(data_data_ok), 1);
      check("t4_rd_data", data_rdata, 32'hA5A5_A5A5);

      // 5: four back-to-back fetches, zero-wait slave
      step();
      inst_req = 1; arready = 1; rvalid = 1; #1;
      for (int k = 0; k < 4; k++) begin
         inst_addr = 32'hBFC0_0200 + 32'(k * 4); #1;
         check("t5_addr_ok", 32'(inst_addr_ok), 1);
         check("t5_data_ok", 32'(inst_data_ok), (k > 0) ? 1 : 0);
         if (k > 0) check("t5_rdata", inst_rdata, 32'h1000_0000 + 32'(k - 1));
         step();
         check("t5_ar", 32'({arvalid, rready}), 32'h2);
         check("t5_araddr", araddr, 32'hBFC0_0200 + 32'(k * 4));
         rdata = 32'h1000_0000 + 32'(k);
         step();
         check("t5_r", 32'({arvalid, rready}), 32'h1);
         step();
      end
      inst_req = 0; arready = 0; rvalid = 0; #1;
      check("t5_last_ok", 32'(inst_data_ok), 1);
      check("t5_last_rdata", inst_rdata, 32'h1000_0003);
      check("t5_idle", 32'(inst_addr_ok), 0);

      // 6: reset while waiting for read data
      step();
      inst_req = 1; inst_addr = 32'hBFC0_0300; #1;
      check("t6_accept", 32'(inst_addr_ok), 1);
      step(); inst_req = 0; arready = 1;
      step(); arready = 0; #1;
      check("t6_in_r", 32'(rready), 1);
      aresetn = 0; rvalid = 1; rdata = 32'hFFFF_FFFF;
      step(); rvalid = 0; #1;
      check("t6_arvalid", 32'(arvalid), 0);
      check("t6_rready", 32'(rready), 0);
      check("t6_oks", 32'({inst_addr_ok, inst_data_ok,
                          data_addr_ok, data_data_ok}), 0);
      check("t6_inst_rdata", inst_rdata, 0);
      check("t6_data_rdata", data_rdata, 0);
      aresetn = 1;
      step();
      data_req = 1; data_wr = 0; data_addr = 32'h8000_3000; #1;
      check("t6_new_accept", 32'(data_addr_ok), 1);
      step(); data_req = 0; #1;
      check("t6_ar", 32'({arvalid, arid}), 32'h11);
      arready = 1;
      step(); arready = 0; rvalid = 1; rdata = 32'h0000_0077;
      step(); rvalid = 0; #1;
      check("t6_rd_ok", 32'(data_data_ok), 1);
      check("t6_rd_data", data_rdata, 32'h0000_0077);
      check("t6_no_inst_ok", 32'(inst_data_ok), 0);

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
